// File: rtl/key_note_encoder.sv
// Piano key front end: synchronises and debounces the key and octave buttons, then
// encodes the held key to a note index with registered note_on/note_off pulses.
module key_note_encoder #(
  parameter int NUM_KEYS        = 7,
  parameter int NOTE_W          = 5,
  parameter int OCT_MAX         = 2,
  parameter int OCT_RESET       = 1,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int MULTI_MODE      = 0,
  localparam int OCT_W          = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                oct_up,
  input  logic                oct_down,
  output logic [NOTE_W-1:0]   note,
  output logic                note_on,
  output logic                note_off,
  output logic [OCT_W-1:0]    octave
);

  localparam int NIN   = NUM_KEYS + 2;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (OCT_RESET < 0 || OCT_RESET > OCT_MAX) begin : g_bad_oct_reset
    $error("key_note_encoder: OCT_RESET outside 0..OCT_MAX");
  end
  if (NUM_KEYS * (OCT_MAX + 1) >= (1 << NOTE_W)) begin : g_bad_note_w
    $error("key_note_encoder: NOTE_W too narrow for NUM_KEYS*(OCT_MAX+1)");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_note_encoder: DEBOUNCE_CYCLES must be at least 1");
  end

  // Input bit layout: keys in the low bits, then octave-up, then octave-down.
  logic [NIN-1:0]      raw;
  logic [NIN-1:0]      sync_a;
  logic [NIN-1:0]      sync_b;
  logic [NIN-1:0]      deb;
  logic [CNT_W-1:0]    cnt [NIN];

  assign raw = {oct_down, oct_up, key};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync_b[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  logic [NUM_KEYS-1:0] deb_keys;
  logic                deb_up;
  logic                deb_down;

  assign deb_keys = deb[NUM_KEYS-1:0];
  assign deb_up   = deb[NUM_KEYS];
  assign deb_down = deb[NUM_KEYS+1];

  typedef enum logic {
    BTN_IDLE,
    BTN_HELD
  } btn_state_t;

  btn_state_t       up_state, up_state_nxt;
  btn_state_t       dn_state, dn_state_nxt;
  logic             up_rise;
  logic             dn_rise;
  logic [OCT_W-1:0] octave_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_state <= BTN_IDLE;
      dn_state <= BTN_IDLE;
      octave   <= OCT_W'(OCT_RESET);
    end else begin
      up_state <= up_state_nxt;
      dn_state <= dn_state_nxt;
      octave   <= octave_nxt;
    end
  end

  always_comb begin
    up_state_nxt = up_state;
    dn_state_nxt = dn_state;
    up_rise      = 1'b0;
    dn_rise      = 1'b0;
    octave_nxt   = octave;

    case (up_state)
      BTN_IDLE: if (deb_up) begin
        up_rise      = 1'b1;
        up_state_nxt = BTN_HELD;
      end
      BTN_HELD: if (!deb_up) up_state_nxt = BTN_IDLE;
      default:  up_state_nxt = BTN_IDLE;
    endcase

    case (dn_state)
      BTN_IDLE: if (deb_down) begin
        dn_rise      = 1'b1;
        dn_state_nxt = BTN_HELD;
      end
      BTN_HELD: if (!deb_down) dn_state_nxt = BTN_IDLE;
      default:  dn_state_nxt = BTN_IDLE;
    endcase

    // Simultaneous up and down presses cancel; both directions saturate.
    if (up_rise && !dn_rise && octave != OCT_W'(OCT_MAX)) begin
      octave_nxt = octave + OCT_W'(1);
    end else if (dn_rise && !up_rise && octave != '0) begin
      octave_nxt = octave - OCT_W'(1);
    end
  end

  logic [NUM_KEYS-1:0] deb_keys_d;
  logic                key_found;
  logic                key_multi;
  logic [NOTE_W-1:0]   key_idx;
  logic [NOTE_W-1:0]   note_enc;
  logic [NOTE_W-1:0]   note_nxt;

  always_comb begin
    key_found = 1'b0;
    key_multi = 1'b0;
    key_idx   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (deb_keys[i]) begin
        if (key_found) begin
          key_multi = 1'b1;
        end else begin
          key_found = 1'b1;
          key_idx   = NOTE_W'(i);
        end
      end
    end
  end

  always_comb begin
    note_enc = '0;
    if (key_found && !(key_multi && MULTI_MODE == 0)) begin
      note_enc = NOTE_W'(octave) * NOTE_W'(NUM_KEYS) + key_idx + NOTE_W'(1);
    end
  end

  // The note is re-evaluated only on a debounced key change, so an octave step
  // while a key is held leaves the sounding note untouched.
  assign note_nxt = (deb_keys != deb_keys_d) ? note_enc : note;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_keys_d <= '0;
      note       <= '0;
      note_on    <= 1'b0;
      note_off   <= 1'b0;
    end else begin
      deb_keys_d <= deb_keys;
      note       <= note_nxt;
      note_on    <= (note_nxt != '0) && (note_nxt != note);
      note_off   <= (note_nxt == '0) && (note != '0);
    end
  end

endmodule

// File: tb/tb_key_note_encoder.sv
// Directed bench for key_note_encoder: two instances (MULTI_MODE 0 and 1) share inputs;
// expected outputs are queued as each step is driven and popped when the DUT should respond.
module tb_key_note_encoder;
  localparam int NK = 7;
  localparam int NW = 5;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic          oct_up;
  logic          oct_down;
  logic [NW-1:0] note0, note1;
  logic          on0, off0, on1, off1;
  logic [OW-1:0] oct0, oct1;

  key_note_encoder #(.DEBOUNCE_CYCLES(4), .MULTI_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .key(key), .oct_up(oct_up), .oct_down(oct_down),
    .note(note0), .note_on(on0), .note_off(off0), .octave(oct0)
  );

  key_note_encoder #(.DEBOUNCE_CYCLES(4), .MULTI_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .key(key), .oct_up(oct_up), .oct_down(oct_down),
    .note(note1), .note_on(on1), .note_off(off1), .octave(oct1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NW-1:0] n0;
    logic [NW-1:0] n1;
    logic          on0;
    logic          off0;
    logic          on1;
    logic          off1;
    logic [OW-1:0] oct0;
    logic [OW-1:0] oct1;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic [NW-1:0] cur0 = '0;
  logic [NW-1:0] cur1 = '0;
  logic [OW-1:0] cur_oct = 2'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [NW-1:0] n0, input logic [NW-1:0] n1,
                      input logic p_on0, input logic p_off0, input logic p_on1,
                      input logic p_off1, input logic [OW-1:0] oct);
    exp_t e;
    e = {n0, n1, p_on0, p_off0, p_on1, p_off1, oct, oct};
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic check_front();
    exp_t  e;
    exp_t  o;
    string t;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    t = tags.pop_front();
    o = {note0, note1, on0, off0, on1, off1, oct0, oct1};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed note=%0d/%0d on/off=%b%b/%b%b oct=%0d/%0d expected note=%0d/%0d on/off=%b%b/%b%b oct=%0d/%0d",
             t, o.n0, o.n1, o.on0, o.off0, o.on1, o.off1, o.oct0, o.oct1,
             e.n0, e.n1, e.on0, e.off0, e.on1, e.off1, e.oct0, e.oct1);
    end
  endtask

  // Drive one input pattern right after an edge; outputs must hold for 6 edges,
  // change with pulses on the 7th, and pulses must clear on the 8th.
  task automatic step(input string tag, input logic [NK-1:0] k, input logic u, input logic d,
                      input logic [NW-1:0] new0, input logic [NW-1:0] new1,
                      input logic [OW-1:0] new_oct);
    logic p_on0, p_off0, p_on1, p_off1;
    p_on0  = (new0 != 0) && (new0 != cur0);
    p_off0 = (new0 == 0) && (cur0 != 0);
    p_on1  = (new1 != 0) && (new1 != cur1);
    p_off1 = (new1 == 0) && (cur1 != 0);
    push({tag, "/pre"}, cur0, cur1, 1'b0, 1'b0, 1'b0, 1'b0, cur_oct);
    push({tag, "/edge"}, new0, new1, p_on0, p_off0, p_on1, p_off1, new_oct);
    push({tag, "/after"}, new0, new1, 1'b0, 1'b0, 1'b0, 1'b0, new_oct);
    key      = k;
    oct_up   = u;
    oct_down = d;
    repeat (6) tick();
    check_front();
    tick();
    check_front();
    tick();
    check_front();
    repeat (2) tick();
    cur0    = new0;
    cur1    = new1;
    cur_oct = new_oct;
  endtask

  initial begin
    // 1: reset with all keys pressed
    rst_n    = 1'b0;
    key      = '1;
    oct_up   = 1'b0;
    oct_down = 1'b0;
    repeat (3) tick();
    push("reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    check_front();
    key   = '0;
    rst_n = 1'b1;
    repeat (3) tick();
    push("reset_release", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    check_front();

    // 2: single key press and release at octave 1
    step("t2_press",   7'h01, 1'b0, 1'b0, 5'd8, 5'd8, 2'd1);
    step("t2_release", 7'h00, 1'b0, 1'b0, 5'd0, 5'd0, 2'd1);

    // 3: 3-cycle glitch never passes the debouncer
    key = 7'h08;
    repeat (3) tick();
    key = 7'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      push("t3_glitch", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
      check_front();
    end

    // 6: held-note freeze across an octave change, then reset mid-note
    step("t6_press",    7'h01, 1'b0, 1'b0, 5'd8, 5'd8, 2'd1);
    step("t6_down",     7'h01, 1'b0, 1'b1, 5'd8, 5'd8, 2'd0);
    step("t6_down_rel", 7'h01, 1'b0, 1'b0, 5'd8, 5'd8, 2'd0);
    step("t6_release",  7'h00, 1'b0, 1'b0, 5'd0, 5'd0, 2'd0);
    step("t6_repress",  7'h01, 1'b0, 1'b0, 5'd1, 5'd1, 2'd0);
    rst_n = 1'b0;
    tick();
    push("t6_reset_held", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    check_front();
    rst_n   = 1'b1;
    cur0    = '0;
    cur1    = '0;
    cur_oct = 2'd1;
    step("t6_after_rst", 7'h01, 1'b0, 1'b0, 5'd8, 5'd8, 2'd1);
    step("t6_rel2",      7'h00, 1'b0, 1'b0, 5'd0, 5'd0, 2'd1);

    // 4: octave stepping, saturation, cancelling presses
    step("t4_up1",      7'h00, 1'b1, 1'b0, 5'd0, 5'd0, 2'd2);
    step("t4_up1_rel",  7'h00, 1'b0, 1'b0, 5'd0, 5'd0, 2'd2);
    step("t4_up2",      7'h00, 1'b1, 1'b0, 5'd0, 5'd0, 2'd2);
    step("t4_up2_rel",  7'h00, 1'b0, 1'b0, 5'd0, 5'd0, 2'd2);
    step("t4_key6",     7'h40, 1'b0, 1'b0, 5'd21, 5'd21, 2'd2);
    step("t4_both",     7'h40, 1'b1, 1'b1, 5'd21, 5'd21, 2'd2);
    step("t4_both_rel", 7'h40, 1'b0, 1'b0, 5'd21, 5'd21, 2'd2);
    step("t4_key6_rel", 7'h00, 1'b0, 1'b0, 5'd0, 5'd0, 2'd2);
    step("t4_down",     7'h00, 1'b0, 1'b1, 5'd0, 5'd0, 2'd1);
    step("t4_down_rel", 7'h00, 1'b0, 1'b0, 5'd0, 5'd0, 2'd1);

    // 5: multi-key handling in both modes, then a direct note-to-note move
    step("t5_multi", 7'h06, 1'b0, 1'b0, 5'd0, 5'd9, 2'd1);
    step("t5_move",  7'h02, 1'b0, 1'b0, 5'd9, 5'd9, 2'd1);
    step("t5_rel",   7'h00, 1'b0, 1'b0, 5'd0, 5'd0, 2'd1);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
